serial_subtractor: RTL and testbench

- Multi-cycle, STEP-bits-per-cycle unsigned subtractor computing diff = a - b; the inverse operation of the team's combinational 32-bit adder wrapper.
- Sits in the same arithmetic datapath.
- Trades area for latency.
- Valid/ready handshake on both input and output.

---
 rtl/serial_arith_pkg.sv | 24 ++
 rtl/serial_subtractor_subtract_slice.sv | 19 +
 rtl/serial_subtractor.sv | 133 +++++++++++++
 tb/tb_serial_subtractor.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the serial arithmetic datapath blocks: FSM encoding,
// default operand geometry and the helpers that derive the step count.
package serial_arith_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_STEP  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of BUSY cycles needed to sweep an operand of the given width.
    function automatic int calc_n(input int width, input int step);
        return width / step;
    endfunction

    // Counter width; never below one bit so a single-step build still elaborates.
    function automatic int calc_cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_subtractor_subtract_slice.sv
// Combinational STEP-bit full subtractor: a + ~b + carry_in, where carry_out=0
// means the slice had to borrow from the next higher slice.
module subtract_slice #(
    parameter int STEP = 4
) (
    input  logic [STEP-1:0] a_slice,
    input  logic [STEP-1:0] b_slice,
    input  logic            carry_in,
    output logic [STEP-1:0] diff_slice,
    output logic            carry_out
);

    logic [STEP:0] w_sum;

    assign w_sum      = {1'b0, a_slice} + {1'b0, ~b_slice} + {{STEP{1'b0}}, carry_in};
    assign diff_slice = w_sum[STEP-1:0];
    assign carry_out  = w_sum[STEP];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle unsigned subtractor: consumes STEP bits of a and b per BUSY cycle,
// LSB first, and presents diff/borrow/zero behind a valid/ready handshake.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int STEP  = DEF_STEP
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_a,
    input  logic [WIDTH-1:0] io_in_b,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out_diff,
    output logic             io_out_borrow,
    output logic             io_out_zero
);

    localparam int N     = calc_n(WIDTH, STEP);
    localparam int CNT_W = calc_cnt_w(N);

    generate
        if ((WIDTH % STEP) != 0 || STEP <= 0) begin : g_bad_geometry
            $error("serial_subtractor: WIDTH must be a positive multiple of STEP");
        end
    endgenerate

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_diff;
    logic               r_carry;
    logic [CNT_W-1:0]   r_count;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_diff_out;
    logic               r_borrow;
    logic               r_zero;

    logic [STEP-1:0]    w_slice_diff;
    logic               w_slice_carry;
    logic [WIDTH-1:0]   w_diff_next;
    logic               w_load;
    logic               w_last;

    subtract_slice #(
        .STEP(STEP)
    ) u_slice (
        .a_slice    (r_a[STEP-1:0]),
        .b_slice    (r_b[STEP-1:0]),
        .carry_in   (r_carry),
        .diff_slice (w_slice_diff),
        .carry_out  (w_slice_carry)
    );

    // New slice enters at the MSB end; after N shifts the LSB slice lands at bit 0.
    assign w_diff_next = (r_diff >> STEP) | (WIDTH'(w_slice_diff) << (WIDTH - STEP));
    assign w_last      = (r_count == CNT_W'(N - 1));

    // DONE accepts new operands in the same cycle the result is taken: no bubble.
    assign io_in_ready = !reset && ((r_state == IDLE) ||
                                    ((r_state == DONE) && io_out_ready));
    assign w_load      = io_in_valid && io_in_ready;

    assign io_out_valid  = r_out_valid;
    assign io_out_diff   = r_diff_out;
    assign io_out_borrow = r_borrow;
    assign io_out_zero   = r_zero;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_diff      <= '0;
            r_carry     <= 1'b1;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_diff_out  <= '0;
            r_borrow    <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_a     <= io_in_a;
                        r_b     <= io_in_b;
                        r_diff  <= '0;
                        r_carry <= 1'b1;
                        r_count <= '0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    r_a     <= r_a >> STEP;
                    r_b     <= r_b >> STEP;
                    r_diff  <= w_diff_next;
                    r_carry <= w_slice_carry;
                    r_count <= r_count + CNT_W'(1);
                    if (w_last) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_diff_out  <= w_diff_next;
                        r_borrow    <= ~w_slice_carry;
                        r_zero      <= (w_diff_next == '0);
                    end
                end
                DONE: begin
                    if (io_out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_load) begin
                            r_a     <= io_in_a;
                            r_b     <= io_in_b;
                            r_diff  <= '0;
                            r_carry <= 1'b1;
                            r_count <= '0;
                            r_state <= BUSY;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: the driver queues hand-computed results
// on acceptance, the monitor checks each handshaken result and its latency.
module tb_serial_subtractor;
    import serial_arith_pkg::*;

    localparam int WIDTH = 32;
    localparam int STEP  = 4;
    localparam int N     = WIDTH / STEP;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             borrow;
        logic             zero;
        int               acc_cyc;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             io_in_valid = 1'b0;
    logic             io_in_ready;
    logic [WIDTH-1:0] io_in_a = '0;
    logic [WIDTH-1:0] io_in_b = '0;
    logic             io_out_valid;
    logic             io_out_ready = 1'b0;
    logic [WIDTH-1:0] io_out_diff;
    logic             io_out_borrow;
    logic             io_out_zero;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic prev_valid = 1'b0;

    serial_subtractor #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clock         (clock),
        .reset         (reset),
        .io_in_valid   (io_in_valid),
        .io_in_ready   (io_in_ready),
        .io_in_a       (io_in_a),
        .io_in_b       (io_in_b),
        .io_out_valid  (io_out_valid),
        .io_out_ready  (io_out_ready),
        .io_out_diff   (io_out_diff),
        .io_out_borrow (io_out_borrow),
        .io_out_zero   (io_out_zero)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("ok   %s: 0x%08h (cycle %0d)", name, act, cyc);
        end
    endtask

    // Monitor: latency on valid rise, payload on each completed output handshake.
    always @(negedge clock) begin
        if (!reset) begin
            if (io_out_valid && !prev_valid) begin
                if (exp_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
                else check("latency", 32'(cyc - exp_q[0].acc_cyc), 32'(N + 1));
            end
            if (io_out_valid && io_out_ready) begin
                if (exp_q.size() == 0) begin
                    check("result_without_stimulus", 32'd1, 32'd0);
                end else begin
                    check("diff", io_out_diff, exp_q[0].diff);
                    check("borrow", 32'(io_out_borrow), 32'(exp_q[0].borrow));
                    check("zero", 32'(io_out_zero), 32'(exp_q[0].zero));
                    void'(exp_q.pop_front());
                end
            end
        end
        prev_valid = io_out_valid;
    end

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] d, input logic br, input logic z);
        exp_t e;
        bit   done = 0;
        io_in_valid = 1'b1;
        io_in_a     = a;
        io_in_b     = b;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clock);
            if (io_in_ready) begin
                e.diff = d; e.borrow = br; e.zero = z; e.acc_cyc = cyc;
                exp_q.push_back(e);
                done = 1;
            end
            @(posedge clock); #1;
        end
        io_in_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        int i = 0;
        while (exp_q.size() != 0 && i < 60) begin
            @(posedge clock); #1;
            i++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_valid();
        int i = 0;
        while (!io_out_valid && i < 60) begin
            @(posedge clock); #1;
            i++;
        end
        if (!io_out_valid) check("valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        // Reset values while reset is held.
        repeat (2) @(negedge clock);
        check("rst_in_ready", 32'(io_in_ready), 32'd0);
        check("rst_out_valid", 32'(io_out_valid), 32'd0);
        check("rst_diff", io_out_diff, 32'd0);
        check("rst_borrow", 32'(io_out_borrow), 32'd0);
        check("rst_zero", 32'(io_out_zero), 32'd0);
        check("rst_count", 32'(dut.r_count), 32'd0);
        check("rst_carry", 32'(dut.r_carry), 32'd1);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("idle_in_ready", 32'(io_in_ready), 32'd1);

        // Basic vectors with the consumer always ready.
        @(posedge clock); #1;
        io_out_ready = 1'b1;
        send(32'd10, 32'd3, 32'd7, 1'b0, 1'b0);
        wait_drain();
        send(32'd3, 32'd10, 32'hFFFF_FFF9, 1'b1, 1'b0);
        wait_drain();
        send(32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b0);
        wait_drain();
        send(32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1);
        wait_drain();
        send(32'd0, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
        wait_drain();

        // Backpressure: result must stay frozen while the consumer stalls.
        io_out_ready = 1'b0;
        send(32'd50, 32'd20, 32'd30, 1'b0, 1'b0);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp_valid", 32'(io_out_valid), 32'd1);
            check("bp_diff", io_out_diff, 32'd30);
            check("bp_borrow", 32'(io_out_borrow), 32'd0);
            check("bp_zero", 32'(io_out_zero), 32'd0);
            check("bp_in_ready", 32'(io_in_ready), 32'd0);
            @(posedge clock); #1;
        end
        io_out_ready = 1'b1;
        @(posedge clock); #1;
        check("bp_release_valid", 32'(io_out_valid), 32'd0);
        check("bp_release_state", 32'(dut.r_state), 32'(IDLE));
        check("bp_release_in_ready", 32'(io_in_ready), 32'd1);
        wait_drain();

        // Back-to-back: new operands accepted in the cycle the result is taken.
        io_out_ready = 1'b0;
        send(32'd7, 32'd2, 32'd5, 1'b0, 1'b0);
        wait_valid();
        io_out_ready = 1'b1;
        send(32'd100, 32'd1, 32'd99, 1'b0, 1'b0);
        wait_drain();

        // Asynchronous reset in the middle of BUSY discards the operation.
        @(posedge clock); #1;
        io_in_valid = 1'b1;
        io_in_a = 32'd1000;
        io_in_b = 32'd1;
        @(posedge clock); #1;
        io_in_valid = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("mid_busy_count", 32'(dut.r_count), 32'd4);
        #2;
        reset = 1'b1;
        #1;
        check("arst_out_valid", 32'(io_out_valid), 32'd0);
        check("arst_state", 32'(dut.r_state), 32'(IDLE));
        check("arst_in_ready", 32'(io_in_ready), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_in_ready", 32'(io_in_ready), 32'd1);
        @(posedge clock); #1;
        send(32'd5, 32'd9, 32'hFFFF_FFFC, 1'b1, 1'b0);
        wait_drain();

        repeat (3) @(posedge clock);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
